btb_update_unit: RTL and testbench
==================================

BTB_UPDATE_UNIT -- requirements
Module: btb_update_unit

Interface
REQ-001 The block SHALL have parameter ADDRESS_LEN, default 16, giving the PC and target width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the update queue entry count; DEPTH SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  Reset; synchronous, active-low.
REQ-005 resolve_valid  input  1  A resolved branch is presented by execute.
REQ-006 resolve_ready  output  1  The unit can accept a branch this cycle.
REQ-007 resolve_pc  input  ADDRESS_LEN  PC of the resolved branch.
REQ-008 resolve_taken  input  1  Actual branch direction.
REQ-009 resolve_target  input  ADDRESS_LEN  Actual taken target.
REQ-010 predicted_hit  input  1  The BTB hit at fetch for this branch.
REQ-011 predicted_target  input  ADDRESS_LEN  Target the BTB supplied at fetch.
REQ-012 write_hold  input  1  Suppresses BTB writes this cycle.
REQ-013 pc_bits_write  output  ADDRESS_LEN  BTB write PC, taken from the queue head.
REQ-014 target_address_in  output  ADDRESS_LEN  BTB write target, taken from the queue head.
REQ-015 write_enabled  output  1  BTB write strobe.
REQ-016 mispredict  output  1  Registered single-cycle redirect pulse.
REQ-017 redirect_pc  output  ADDRESS_LEN  Correct fetch PC; valid while mispredict=1.
REQ-018 count  output  log2(DEPTH)+1  Number of occupied queue entries.

Function
REQ-019 A branch SHALL be accepted on any cycle where resolve_valid=1 and resolve_ready=1.
REQ-020 resolve_ready SHALL equal (count != DEPTH) and SHALL not depend on resolve_valid.
REQ-021 An accepted branch SHALL be classed as a mispredict when either condition holds:
- taken and (not predicted_hit, or predicted_target != resolve_target);
- not taken and predicted_hit.
REQ-022 When an accepted branch is a mispredict, mispredict SHALL be 1 in the following cycle only.
REQ-023 In that cycle, redirect_pc SHALL be resolve_target if the branch was taken, else resolve_pc+1 modulo 2^ADDRESS_LEN.
REQ-024 Outside a mispredict pulse, redirect_pc SHALL hold its last value.
REQ-025 An accepted branch SHALL need an update when it is taken and (not predicted_hit, or predicted_target != resolve_target).
REQ-026 Not-taken branches SHALL never be enqueued.
REQ-027 When an accepted branch needs an update, a {resolve_pc, resolve_target} entry SHALL be pushed at the accepting clock edge, except as coalesced under REQ-028.
REQ-028 Coalescing SHALL apply when all of the following hold: count>0, the youngest entry's PC equals resolve_pc, and the youngest entry is not being popped in the same cycle.
- In that case the youngest entry's target SHALL be overwritten with resolve_target.
- count SHALL not change.
REQ-029 If the youngest entry with a matching PC is being popped in the same cycle, a new entry SHALL be pushed instead of coalescing.
REQ-030 write_enabled SHALL equal (count>0 and write_hold=0).
REQ-031 Each cycle with write_enabled=1 SHALL pop the head entry at the clock edge; the BTB SHALL not back-pressure the unit.
REQ-032 While count=0, pc_bits_write and target_address_in SHALL hold the last popped values, or 0 if nothing has been popped since reset.
REQ-033 An entry pushed at edge N SHALL produce write_enabled=1 no earlier than cycle N+1; entries SHALL drain in FIFO order.
REQ-034 A simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH-1 and count=1.
REQ-035 At count=DEPTH, resolve_ready=0.
- A branch presented at full SHALL not be accepted and SHALL produce no mispredict.
- The upstream stage SHALL hold resolve_valid and its data until accepted.
REQ-036 The read and write pointers SHALL wrap modulo DEPTH.
REQ-037 Arithmetic on resolve_pc+1 SHALL be ADDRESS_LEN wide and wrap, so 0xFFFF+1 = 0x0000.

Reset
REQ-038 While reset=0 at a rising edge, the unit SHALL set:
- count=0 and both pointers to 0;
- mispredict=0, write_enabled=0, redirect_pc=0;
- pc_bits_write=0, target_address_in=0.
REQ-039 resolve_ready SHALL be 0 while reset=0 and SHALL become 1 in the first cycle after reset deasserts.
REQ-040 Reset asserted mid-operation SHALL discard all queued entries and any pending mispredict pulse within the same edge.

Verification
REQ-041 Cold miss: accept pc=0x0010, taken=1, target=0x0200, predicted_hit=0 -> next cycle mispredict=1, redirect_pc=0x0200, write_enabled=1, pc_bits_write=0x0010, target_address_in=0x0200; count returns to 0.
REQ-042 Correct prediction: pc=0x0020, taken=1, target=0x0300, predicted_hit=1, predicted_target=0x0300 -> no mispredict, no write.
REQ-043 False hit: pc=0xFFFF, taken=0, predicted_hit=1 -> mispredict=1, redirect_pc=0x0000, no write.
REQ-044 Fill then stall: write_hold=1; push 4 distinct update branches -> count=4, resolve_ready=0, a fifth branch is not accepted.
REQ-045 Drain after stall (continues REQ-044): release write_hold -> four consecutive write_enabled cycles in push order.
REQ-046 Coalescing: write_hold=1; push pc=0x0040/target 0x0100, then pc=0x0040/target 0x0180 -> count=1. After release, a single write of 0x0180.
REQ-047 Reset mid-operation: assert reset with count=3 -> next cycle count=0, write_enabled=0, mispredict=0.

Source files
------------

// File: rtl/btb_update_unit.sv
// Resolved-branch handler: raises a one-cycle redirect on mispredict and queues BTB
// target updates in a small FIFO, folding a repeat of the youngest PC into that entry.
module btb_update_unit #(
    parameter int ADDRESS_LEN = 16,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   resolve_valid,
    output logic                   resolve_ready,
    input  logic [ADDRESS_LEN-1:0] resolve_pc,
    input  logic                   resolve_taken,
    input  logic [ADDRESS_LEN-1:0] resolve_target,
    input  logic                   predicted_hit,
    input  logic [ADDRESS_LEN-1:0] predicted_target,
    input  logic                   write_hold,
    output logic [ADDRESS_LEN-1:0] pc_bits_write,
    output logic [ADDRESS_LEN-1:0] target_address_in,
    output logic                   write_enabled,
    output logic                   mispredict,
    output logic [ADDRESS_LEN-1:0] redirect_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDRESS_LEN-1:0] pc_mem_q  [DEPTH];
    logic [ADDRESS_LEN-1:0] pc_mem_d  [DEPTH];
    logic [ADDRESS_LEN-1:0] tgt_mem_q [DEPTH];
    logic [ADDRESS_LEN-1:0] tgt_mem_d [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       young_ptr;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   mispredict_q, mispredict_d;
    logic [ADDRESS_LEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [ADDRESS_LEN-1:0] last_pc_q, last_pc_d;
    logic [ADDRESS_LEN-1:0] last_tgt_q, last_tgt_d;

    logic accept;
    logic target_wrong;
    logic is_mispredict;
    logic needs_update;
    logic pop;
    logic coalesce;
    logic push;

    assign resolve_ready     = reset && (count_q != FULL);
    assign write_enabled     = (count_q != '0) && !write_hold;
    assign pc_bits_write     = (count_q != '0) ? pc_mem_q[rd_ptr_q]  : last_pc_q;
    assign target_address_in = (count_q != '0) ? tgt_mem_q[rd_ptr_q] : last_tgt_q;
    assign mispredict        = mispredict_q;
    assign redirect_pc       = redirect_pc_q;
    assign count             = count_q;

    always_comb begin
        target_wrong  = !predicted_hit || (predicted_target != resolve_target);
        accept        = resolve_valid && resolve_ready;
        is_mispredict = resolve_taken ? target_wrong : predicted_hit;
        needs_update  = resolve_taken && target_wrong;
        pop           = write_enabled;
        young_ptr     = wr_ptr_q - PTR_W'(1);
        // An entry leaving at this edge cannot absorb the new target, so push a fresh one.
        coalesce      = accept && needs_update && (count_q != '0)
                        && (pc_mem_q[young_ptr] == resolve_pc)
                        && !(pop && (count_q == CNT_W'(1)));
        push          = accept && needs_update && !coalesce;

        pc_mem_d  = pc_mem_q;
        tgt_mem_d = tgt_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]  = resolve_pc;
            tgt_mem_d[wr_ptr_q] = resolve_target;
        end
        if (coalesce) begin
            tgt_mem_d[young_ptr] = resolve_target;
        end

        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        last_pc_d  = pop ? pc_mem_q[rd_ptr_q]  : last_pc_q;
        last_tgt_d = pop ? tgt_mem_q[rd_ptr_q] : last_tgt_q;

        mispredict_d  = accept && is_mispredict;
        redirect_pc_d = redirect_pc_q;
        if (accept && is_mispredict) begin
            redirect_pc_d = resolve_taken ? resolve_target : resolve_pc + ADDRESS_LEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                tgt_mem_q[i] <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            last_pc_q     <= '0;
            last_tgt_q    <= '0;
        end else begin
            pc_mem_q      <= pc_mem_d;
            tgt_mem_q     <= tgt_mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            last_pc_q     <= last_pc_d;
            last_tgt_q    <= last_tgt_d;
        end
    end
endmodule

// File: tb/tb_btb_update_unit.sv
// Bench for btb_update_unit: a queue-level reference model predicts BTB writes and
// redirects per cycle, and a negedge monitor scores the DUT against those predictions.
`timescale 1ns/1ps
module tb_btb_update_unit;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          resolve_valid = 1'b0;
    logic          resolve_ready;
    logic [AW-1:0] resolve_pc = '0;
    logic          resolve_taken = 1'b0;
    logic [AW-1:0] resolve_target = '0;
    logic          predicted_hit = 1'b0;
    logic [AW-1:0] predicted_target = '0;
    logic          write_hold = 1'b0;
    logic [AW-1:0] pc_bits_write;
    logic [AW-1:0] target_address_in;
    logic          write_enabled;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic [2:0]    count;

    btb_update_unit #(.ADDRESS_LEN(AW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .resolve_valid    (resolve_valid),
        .resolve_ready    (resolve_ready),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .predicted_hit    (predicted_hit),
        .predicted_target (predicted_target),
        .write_hold       (write_hold),
        .pc_bits_write    (pc_bits_write),
        .target_address_in(target_address_in),
        .write_enabled    (write_enabled),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .count            (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } exp_t;

    exp_t          wr_exp[$];
    exp_t          mp_exp[$];
    logic [AW-1:0] mpc[$];
    logic [AW-1:0] mtgt[$];

    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            armed = 1'b0;
    bit            model_live = 1'b0;
    bit            last_accepted = 1'b0;
    int            exp_count = 0;
    bit            exp_ready = 1'b0;
    logic [AW-1:0] exp_redirect = '0;
    logic [AW-1:0] exp_hold_pc = '0;
    logic [AW-1:0] exp_hold_tgt = '0;
    logic [AW-1:0] redir_state = '0;
    logic [AW-1:0] hold_pc_state = '0;
    logic [AW-1:0] hold_tgt_state = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model across the coming edge.
    task automatic applyStimulus(input logic rst_n, input logic hold, input logic v,
                                 input logic [AW-1:0] pc, input logic taken,
                                 input logic [AW-1:0] tgt, input logic hit,
                                 input logic [AW-1:0] ptgt);
        int            sz;
        bit            pop;
        bit            acc;
        bit            mis;
        bit            upd;
        logic [AW-1:0] nr;
        exp_t          e;
        @(posedge clk);
        #1;
        reset            = rst_n;
        write_hold       = hold;
        resolve_valid    = v;
        resolve_pc       = pc;
        resolve_taken    = taken;
        resolve_target   = tgt;
        predicted_hit    = hit;
        predicted_target = ptgt;

        sz           = mpc.size();
        exp_count    = sz;
        exp_ready    = rst_n && (sz < DEPTH);
        exp_redirect = redir_state;
        exp_hold_pc  = hold_pc_state;
        exp_hold_tgt = hold_tgt_state;
        model_live   = armed;

        pop = (sz > 0) && !hold;
        if (pop) begin
            e.due = cyc; e.a = mpc[0]; e.b = mtgt[0];
            wr_exp.push_back(e);
        end
        acc = v && exp_ready;
        last_accepted = acc;
        if (acc) begin
            if (taken) mis = !hit || (ptgt != tgt);
            else       mis = hit;
            upd = taken && (!hit || (ptgt != tgt));
            if (mis) begin
                nr = taken ? tgt : pc + 16'd1;
                e.due = cyc + 1; e.a = nr; e.b = '0;
                mp_exp.push_back(e);
                redir_state = nr;
            end
            if (upd) begin
                if (sz > 0 && mpc[sz-1] == pc && !(pop && sz == 1)) mtgt[sz-1] = tgt;
                else begin
                    mpc.push_back(pc);
                    mtgt.push_back(tgt);
                end
            end
        end
        if (pop) begin
            hold_pc_state  = mpc[0];
            hold_tgt_state = mtgt[0];
            void'(mpc.pop_front());
            void'(mtgt.pop_front());
        end
        if (!rst_n) begin
            mpc.delete();
            mtgt.delete();
            hold_pc_state  = '0;
            hold_tgt_state = '0;
            redir_state    = '0;
        end
    endtask

    task automatic idle(input logic hold);
        applyStimulus(1'b1, hold, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    // Monitor: scores every modelled cycle, popping expected writes/redirects when due.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("count", 32'(count), 32'(exp_count));
            checkOutput("resolve_ready", 32'(resolve_ready), 32'(exp_ready));
            checkOutput("redirect_pc", 32'(redirect_pc), 32'(exp_redirect));
            if (exp_count == 0) begin
                checkOutput("idle_pc_bits_write", 32'(pc_bits_write), 32'(exp_hold_pc));
                checkOutput("idle_target_address_in", 32'(target_address_in), 32'(exp_hold_tgt));
            end
            if (wr_exp.size() > 0 && wr_exp[0].due == cyc) begin
                checkOutput("write_enabled", 32'(write_enabled), 32'd1);
                checkOutput("write_pc", 32'(pc_bits_write), 32'(wr_exp[0].a));
                checkOutput("write_target", 32'(target_address_in), 32'(wr_exp[0].b));
                void'(wr_exp.pop_front());
            end else begin
                checkOutput("write_enabled_quiet", 32'(write_enabled), 32'd0);
            end
            if (mp_exp.size() > 0 && mp_exp[0].due == cyc) begin
                checkOutput("mispredict", 32'(mispredict), 32'd1);
                checkOutput("mispredict_redirect", 32'(redirect_pc), 32'(mp_exp[0].a));
                void'(mp_exp.pop_front());
            end else begin
                checkOutput("mispredict_quiet", 32'(mispredict), 32'd0);
            end
        end
    end

    initial begin
        logic          v;
        logic [AW-1:0] pc;
        logic          taken;
        logic [AW-1:0] tgt;
        logic          hit;
        logic [AW-1:0] ptgt;
        logic          hold;
        logic          rst_n;
        bit            pending;
        logic [AW-1:0] pcs [4];
        pcs[0] = 16'h0040; pcs[1] = 16'h0041; pcs[2] = 16'hFFFF; pcs[3] = 16'h07F0;

        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        armed = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0200, 1'b0, '0);
        @(negedge clk);
        checkOutput("reset_ready", 32'(resolve_ready), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_pc_bits_write", 32'(pc_bits_write), 32'd0);

        $display("[TB] cold miss");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0200, 1'b0, '0);
        idle(1'b0);
        @(negedge clk);
        checkOutput("cold_mispredict", 32'(mispredict), 32'd1);
        checkOutput("cold_redirect", 32'(redirect_pc), 32'h0200);
        checkOutput("cold_write_enabled", 32'(write_enabled), 32'd1);
        checkOutput("cold_pc_bits_write", 32'(pc_bits_write), 32'h0010);
        checkOutput("cold_target", 32'(target_address_in), 32'h0200);
        idle(1'b0);
        @(negedge clk);
        checkOutput("cold_count_back", 32'(count), 32'd0);

        $display("[TB] correct prediction");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0300, 1'b1, 16'h0300);
        idle(1'b0);
        @(negedge clk);
        checkOutput("correct_mispredict", 32'(mispredict), 32'd0);
        checkOutput("correct_write_enabled", 32'(write_enabled), 32'd0);

        $display("[TB] false hit");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h1234);
        idle(1'b0);
        @(negedge clk);
        checkOutput("false_hit_mispredict", 32'(mispredict), 32'd1);
        checkOutput("false_hit_redirect", 32'(redirect_pc), 32'h0000);
        checkOutput("false_hit_write_enabled", 32'(write_enabled), 32'd0);

        $display("[TB] fill, stall, drain");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'(16'h0100 + i), 1'b1, 16'(16'h0500 + i), 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0104, 1'b1, 16'h0504, 1'b0, '0);
        @(negedge clk);
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_ready", 32'(resolve_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0104, 1'b1, 16'h0504, 1'b0, '0);
        @(negedge clk);
        checkOutput("full_no_mispredict", 32'(mispredict), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0104, 1'b1, 16'h0504, 1'b0, '0);
        @(negedge clk);
        checkOutput("drain_first_pc", 32'(pc_bits_write), 32'h0100);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0104, 1'b1, 16'h0504, 1'b0, '0);
        @(negedge clk);
        checkOutput("drain_second_pc", 32'(pc_bits_write), 32'h0101);
        checkOutput("drain_push_pop_count", 32'(count), 32'd3);
        repeat (6) idle(1'b0);

        $display("[TB] coalescing");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0180, 1'b0, '0);
        idle(1'b1);
        @(negedge clk);
        checkOutput("coalesce_count", 32'(count), 32'd1);
        checkOutput("coalesce_target", 32'(target_address_in), 32'h0180);
        idle(1'b0);
        @(negedge clk);
        checkOutput("coalesce_write_target", 32'(target_address_in), 32'h0180);
        idle(1'b0);
        @(negedge clk);
        checkOutput("coalesce_single_write", 32'(write_enabled), 32'd0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'(16'h0060 + i), 1'b1, 16'(16'h0700 + i), 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        idle(1'b0);
        @(negedge clk);
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_write_enabled", 32'(write_enabled), 32'd0);
        checkOutput("midreset_mispredict", 32'(mispredict), 32'd0);

        $display("[TB] randomized traffic");
        pending = 1'b0;
        v = 1'b0; pc = '0; taken = 1'b0; tgt = '0; hit = 1'b0; ptgt = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!pending) begin
                v     = ($urandom_range(0, 9) < 6);
                pc    = pcs[$urandom_range(0, 3)];
                taken = ($urandom_range(0, 9) < 6);
                tgt   = 16'(16'h0200 + 16'($urandom_range(0, 3)) * 16'h0010);
                hit   = $urandom_range(0, 1) == 1;
                ptgt  = ($urandom_range(0, 1) == 1) ? tgt : 16'($urandom);
            end
            hold  = ($urandom_range(0, 9) < 4);
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(rst_n, hold, v, pc, taken, tgt, hit, ptgt);
            pending = v && !last_accepted;
        end
        repeat (8) idle(1'b0);
        @(posedge clk);
        #1;
        model_live = 1'b0;
        checkOutput("redirects_all_seen", 32'(mp_exp.size()), 32'd0);
        checkOutput("final_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
